// File: rtl/ssm_bit_funnel.sv
// Bit funnel for one SSM: packs 32-bit stream words into an MSB-aligned bit buffer
// and exposes the next WIN_W unparsed bits to the downstream size decoders.
module ssm_bit_funnel #(
   parameter int ssm_idx = 0,
   parameter int IN_W    = 32,
   parameter int WIN_W   = 128,
   parameter int BUF_W   = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [IN_W-1:0]   in_data,
   output logic              in_ready,
   output logic [WIN_W-1:0]  suffix,
   output logic              suffix_valid,
   input  logic              consume_en,
   input  logic [7:0]        consume_bits,
   output logic [8:0]        fill,
   output logic [23:0]       bits_consumed,
   output logic              err
);

   localparam logic [8:0] PUSH_LIMIT = 9'(BUF_W - IN_W);
   localparam logic [8:0] WIN_BITS   = 9'(WIN_W);
   localparam logic [8:0] WORD_BITS  = 9'(IN_W);
   localparam bit         CFG_OK     = (BUF_W >= WIN_W + IN_W) && (BUF_W <= 256) && (ssm_idx >= 0);

   if (!CFG_OK) begin : g_cfg_err
      $error("ssm_bit_funnel: illegal parameter set");
   end

   logic [BUF_W-1:0] buf_q, buf_d;
   logic [8:0]       fill_q, fill_d;
   logic [23:0]      bc_q, bc_d;
   logic             err_q, err_d;

   logic             acc;
   logic             cons_ok;
   logic [8:0]       c_bits;
   logic [8:0]       rem_bits;
   logic [BUF_W-1:0] word_ext;

   // Readiness looks only at the registered fill so the producer never sees a
   // path through consume; flush blocks acceptance for its whole cycle.
   assign in_ready     = (fill_q <= PUSH_LIMIT) & ~flush;
   assign suffix_valid = (fill_q >= WIN_BITS);
   assign suffix       = buf_q[BUF_W-1 -: WIN_W];
   assign fill         = fill_q;
   assign bits_consumed = bc_q;
   assign err          = err_q;

   always_comb begin
      acc      = in_valid & in_ready;
      cons_ok  = consume_en & suffix_valid & ({1'b0, consume_bits} <= WIN_BITS);
      c_bits   = cons_ok ? {1'b0, consume_bits} : 9'd0;
      rem_bits = fill_q - c_bits;
      word_ext = BUF_W'(in_data);

      // Shift out consumed bits first, then append the new word right behind
      // whatever remains; bits below fill stay zero so OR-ing is safe.
      buf_d    = buf_q << c_bits;
      if (acc) begin
         buf_d = buf_d | (word_ext << (PUSH_LIMIT - rem_bits));
      end
      fill_d   = rem_bits + (acc ? WORD_BITS : 9'd0);
      bc_d     = bc_q + 24'(c_bits);
      err_d    = err_q | (consume_en & ~cons_ok);

      if (flush) begin
         buf_d  = '0;
         fill_d = '0;
         bc_d   = '0;
         err_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q  <= '0;
         fill_q <= '0;
         bc_q   <= '0;
         err_q  <= 1'b0;
      end else begin
         buf_q  <= buf_d;
         fill_q <= fill_d;
         bc_q   <= bc_d;
         err_q  <= err_d;
      end
   end

endmodule

// File: tb/tb_ssm_bit_funnel.sv
// Bench for ssm_bit_funnel: a bit-queue reference predicts every cycle into a
// scoreboard, plus hand-computed checkpoints along the directed sequence.
module tb_ssm_bit_funnel;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic [31:0]  in_data;
   logic         in_ready;
   logic [127:0] suffix;
   logic         suffix_valid;
   logic         consume_en;
   logic [7:0]   consume_bits;
   logic [8:0]   fill;
   logic [23:0]  bits_consumed;
   logic         err;

   ssm_bit_funnel #(.ssm_idx(0), .IN_W(32), .WIN_W(128), .BUF_W(256)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .suffix        (suffix),
      .suffix_valid  (suffix_valid),
      .consume_en    (consume_en),
      .consume_bits  (consume_bits),
      .fill          (fill),
      .bits_consumed (bits_consumed),
      .err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]   fill;
      logic [127:0] suffix;
      logic         sv;
      logic [23:0]  bc;
      logic         err;
      logic         rdy;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   // Reference: stream bits in order, front = next unparsed bit.
   bit   mq[$];
   int   m_bc  = 0;
   bit   m_err = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic step(input bit fl, input bit iv, input logic [31:0] d,
                       input bit ce, input logic [7:0] cb);
      int   sz;
      int   c;
      bit   acc;
      exp_t e;
      sz  = mq.size();
      acc = iv && !fl && (sz <= 224);
      c   = 0;
      if (fl) begin
         mq.delete();
         m_bc  = 0;
         m_err = 0;
      end else begin
         if (ce) begin
            if (sz >= 128 && int'(cb) <= 128) c = int'(cb);
            else m_err = 1;
         end
         repeat (c) void'(mq.pop_front());
         if (acc) for (int i = 31; i >= 0; i--) mq.push_back(d[i]);
         m_bc = (m_bc + c) % (1 << 24);
      end
      e.fill = 9'(mq.size());
      e.suffix = '0;
      for (int i = 0; i < 128; i++) e.suffix[127-i] = (i < mq.size()) ? mq[i] : 1'b0;
      e.sv  = (mq.size() >= 128);
      e.bc  = 24'(m_bc);
      e.err = m_err;
      e.rdy = (mq.size() <= 224);
      exp_q.push_back(e);

      flush        = fl;
      in_valid     = iv;
      in_data      = d;
      consume_en   = ce;
      consume_bits = cb;
      @(posedge clk);
      #1;
      flush        = 1'b0;
      in_valid     = 1'b0;
      in_data      = '0;
      consume_en   = 1'b0;
      consume_bits = '0;
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] d);
      step(1'b0, 1'b1, d, 1'b0, 8'd0);
   endtask

   task automatic consume(input logic [7:0] cb);
      step(1'b0, 1'b0, 32'd0, 1'b1, cb);
   endtask

   // Monitor: compares registered outputs shortly after each edge, with idle inputs.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_fill",   128'(fill),          128'(e.fill));
            chk("sb_suffix", suffix,              e.suffix);
            chk("sb_valid",  128'(suffix_valid),  128'(e.sv));
            chk("sb_bc",     128'(bits_consumed), 128'(e.bc));
            chk("sb_err",    128'(err),           128'(e.err));
            chk("sb_ready",  128'(in_ready),      128'(e.rdy));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] w0;
      logic [127:0] s;
      logic [31:0]  p [8];
      logic [31:0]  h;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      consume_en = 1'b0; consume_bits = '0;
      #2;
      chk("rst_fill",  128'(fill),          128'd0);
      chk("rst_suffix", suffix,             128'd0);
      chk("rst_valid", 128'(suffix_valid),  128'd0);
      chk("rst_ready", 128'(in_ready),      128'd1);
      chk("rst_bc",    128'(bits_consumed), 128'd0);
      chk("rst_err",   128'(err),           128'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Four back-to-back words fill exactly one window.
      push(32'hDEADBEEF);
      push(32'h01234567);
      push(32'h89ABCDEF);
      $display("txn push3 fill=%0d valid=%0d", fill, suffix_valid);
      chk("t1_valid_early", 128'(suffix_valid), 128'd0);
      push(32'hCAFEF00D);
      $display("txn push4 fill=%0d suffix=%h", fill, suffix);
      w0 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      chk("t1_suffix", suffix, w0);
      chk("t1_fill",   128'(fill), 128'd128);
      chk("t1_valid",  128'(suffix_valid), 128'd1);

      // Consume 37 and push together: 91 old bits remain, new word sits right behind.
      step(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 8'd37);
      $display("txn consume37+push fill=%0d suffix=%h", fill, suffix);
      s = 128'hFFFFFFFF;
      chk("t2_fill",   128'(fill), 128'd123);
      chk("t2_valid",  128'(suffix_valid), 128'd0);
      chk("t2_bc",     128'(bits_consumed), 128'd37);
      chk("t2_suffix", suffix, (w0 << 37) | (s << 5));

      // Fill to 256, back-pressure, then release with a consume.
      step(1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
      for (int i = 0; i < 8; i++) begin
         p[i] = 32'h1000_0001 * (i + 1) ^ 32'hA5A5_0000;
         push(p[i]);
         $display("txn fillpush%0d fill=%0d ready=%0d", i, fill, in_ready);
      end
      chk("t3_full_fill",  128'(fill), 128'd256);
      chk("t3_full_ready", 128'(in_ready), 128'd0);
      h = 32'h13579BDF;
      push(h);
      chk("t3_held_fill", 128'(fill), 128'd256);
      step(1'b0, 1'b1, h, 1'b1, 8'd32);
      $display("txn consume32 held fill=%0d ready=%0d", fill, in_ready);
      chk("t3_c32_fill",  128'(fill), 128'd224);
      chk("t3_c32_ready", 128'(in_ready), 128'd1);
      push(h);
      chk("t3_land_fill", 128'(fill), 128'd256);

      // Consume 0, 128, 5 on the full buffer.
      consume(8'd0);
      chk("t4_c0_fill", 128'(fill), 128'd256);
      chk("t4_c0_bc",   128'(bits_consumed), 128'd32);
      consume(8'd128);
      $display("txn consume128 fill=%0d suffix=%h", fill, suffix);
      chk("t4_c128_fill",   128'(fill), 128'd128);
      chk("t4_c128_suffix", suffix, {p[5], p[6], p[7], h});
      consume(8'd5);
      chk("t4_c5_fill", 128'(fill), 128'd123);
      chk("t4_bc",      128'(bits_consumed), 128'd165);
      chk("t4_err",     128'(err), 128'd0);

      // Protocol errors are sticky and leave state alone.
      push(32'h0F0F0F0F);
      consume(8'd129);
      $display("txn consume129 fill=%0d err=%0d", fill, err);
      chk("t5_err129",  128'(err), 128'd1);
      chk("t5_fill129", 128'(fill), 128'd155);
      consume(8'd91);
      chk("t5_fill64", 128'(fill), 128'd64);
      consume(8'd4);
      chk("t5_err_invalid",  128'(err), 128'd1);
      chk("t5_fill_invalid", 128'(fill), 128'd64);
      step(1'b1, 1'b1, 32'hFFFF0000, 1'b1, 8'd10);
      $display("txn flush fill=%0d bc=%0d err=%0d", fill, bits_consumed, err);
      chk("t5_flush_fill", 128'(fill), 128'd0);
      chk("t5_flush_bc",   128'(bits_consumed), 128'd0);
      chk("t5_flush_err",  128'(err), 128'd0);

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 7; i++) push(32'h5555_0000 + 32'(i));
      consume(8'd24);
      chk("t6_fill200", 128'(fill), 128'd200);
      #1;
      rst_n = 1'b0;
      #1;
      $display("txn async_reset fill=%0d ready=%0d", fill, in_ready);
      chk("t6_rst_fill",   128'(fill), 128'd0);
      chk("t6_rst_suffix", suffix, 128'd0);
      chk("t6_rst_bc",     128'(bits_consumed), 128'd0);
      chk("t6_rst_ready",  128'(in_ready), 128'd1);
      mq.delete();
      m_bc  = 0;
      m_err = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(32'h80000000);
      s = suffix;
      $display("txn push_after_reset fill=%0d suffix=%h", fill, suffix);
      chk("t6_msb",  128'(s[127]), 128'd1);
      chk("t6_fill", 128'(fill), 128'd32);

      @(negedge clk); @(negedge clk);
      chk("sb_drained", 128'(exp_q.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
